// File: rtl/ram_master.sv
// Bus initiator for the shared tristate memory bus: accepts single read/write
// requests and sequences enable/rw plus the tri_buf controls for each phase.
module ram_master #(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             enable,
  output logic             rw,
  output logic             bus_tri_rw,
  output logic [WIDTH-1:0] bus_tri_data,
  input  logic [WIDTH-1:0] bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

  // Last turnaround count value; only reachable when TURNAROUND >= 1.
  localparam logic [1:0] TURN_LAST = 2'(TURNAROUND - 1);

  state_t           state;
  logic             lat_write;
  logic [WIDTH-1:0] lat_wdata;
  logic [1:0]       turn_cnt;

  // Only output decoded from state; forced low while reset is held.
  assign req_ready = (state == IDLE) && !reset;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_wdata    <= '0;
      turn_cnt     <= '0;
      enable       <= 1'b0;
      rw           <= 1'b0;
      bus_tri_rw   <= 1'b0;
      bus_tri_data <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            // bus_tri_data doubles as the address latch for the ADDR phase.
            lat_write    <= req_write;
            lat_wdata    <= req_wdata;
            enable       <= 1'b1;
            rw           <= req_write;
            bus_tri_rw   <= 1'b1;
            bus_tri_data <= req_addr;
            state        <= ADDR;
          end
        end
        ADDR: begin
          // Reads release the bus here so the responder can drive it in DATA.
          rw           <= lat_write;
          bus_tri_rw   <= lat_write;
          bus_tri_data <= lat_write ? lat_wdata : '0;
          state        <= DATA;
        end
        DATA: begin
          enable       <= 1'b0;
          rw           <= 1'b0;
          bus_tri_rw   <= 1'b0;
          bus_tri_data <= '0;
          rsp_valid    <= 1'b1;
          turn_cnt     <= '0;
          if (!lat_write) begin
            rsp_rdata <= bus;
          end
          if (!lat_write && (TURNAROUND > 0)) begin
            state <= TURN;
          end else begin
            state <= IDLE;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
